// File: rtl/subleq_pkg.sv
// Shared definitions for the subleq bit-serial datapath: capture FSM states,
// lane widths and the bit-index mapping used by both the sending and receiving ends.
package subleq_pkg;

  localparam int BYTE_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Both ends of the 8x1 path derive the bit position from the same counter value.
  function automatic logic [SEL_W-1:0] sel_map(input logic [SEL_W-1:0] count,
                                               input bit lsb_first);
    if (lsb_first) begin
      return count;
    end else begin
      return 3'd7 - count;
    end
  endfunction

endpackage

// File: rtl/bit_deser_8x1_if.sv
// Serial-in / byte-out bundle of the bit deserializer; master drives the serial
// side and accepts the byte, slave is the deserializer itself.
interface bit_deser_8x1_if;
  import subleq_pkg::*;

  logic              start;
  logic              bit_in;
  logic              bit_valid;
  logic [BYTE_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic [SEL_W-1:0]  sel_out;
  logic              overrun;

  modport master (
    output start, bit_in, bit_valid, data_ready,
    input  data_out, data_valid, busy, sel_out, overrun
  );

  modport slave (
    input  start, bit_in, bit_valid, data_ready,
    output data_out, data_valid, busy, sel_out, overrun
  );

endinterface

// File: rtl/bit_deser_8x1.sv
// Serial-to-parallel capture: assembles one byte from a 1-bit lane and offers it
// on a valid/ready port; sel_out tracks the index the sending mux will drive.
module bit_deser_8x1
  import subleq_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  bit_deser_8x1_if.slave  bus
);

  localparam bit LSB_FIRST_B = (LSB_FIRST != 0);

  state_e            state_r;
  logic [SEL_W-1:0]  count_r;
  logic [SEL_W-1:0]  sel_r;
  logic [BYTE_W-1:0] shift_r;
  logic [BYTE_W-1:0] data_out_r;
  logic              data_valid_r;
  logic              busy_r;
  logic              overrun_r;
  logic [BYTE_W-1:0] shift_bit_s;

  // Partial byte with the incoming bit already placed at the current index.
  always_comb begin
    shift_bit_s         = shift_r;
    shift_bit_s[sel_r]  = bus.bit_in;
  end

  // Capture FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      count_r      <= 3'd0;
      sel_r        <= sel_map(3'd0, LSB_FIRST_B);
      shift_r      <= 8'h00;
      data_out_r   <= 8'h00;
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r   <= ST_SHIFT;
            busy_r    <= 1'b1;
            count_r   <= 3'd0;
            sel_r     <= sel_map(3'd0, LSB_FIRST_B);
            shift_r   <= 8'h00;
            overrun_r <= 1'b0;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (bus.start) begin
            // Restart wins over a coincident bit: the bit is dropped.
            count_r   <= 3'd0;
            sel_r     <= sel_map(3'd0, LSB_FIRST_B);
            shift_r   <= 8'h00;
            overrun_r <= 1'b0;
          end else if (bus.bit_valid) begin
            if (count_r == 3'd7) begin
              state_r      <= ST_HOLD;
              busy_r       <= 1'b0;
              data_out_r   <= shift_bit_s;
              data_valid_r <= 1'b1;
              count_r      <= 3'd0;
              sel_r        <= sel_map(3'd0, LSB_FIRST_B);
              shift_r      <= 8'h00;
            end else begin
              shift_r <= shift_bit_s;
              count_r <= count_r + 3'd1;
              sel_r   <= sel_map(count_r + 3'd1, LSB_FIRST_B);
            end
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_HOLD: begin
          if (bus.data_ready && bus.start) begin
            state_r      <= ST_SHIFT;
            busy_r       <= 1'b1;
            data_valid_r <= 1'b0;
            shift_r      <= 8'h00;
            overrun_r    <= 1'b0;
          end else if (bus.data_ready) begin
            state_r      <= ST_IDLE;
            data_valid_r <= 1'b0;
            overrun_r    <= overrun_r | bus.bit_valid;
          end else begin
            state_r      <= ST_HOLD;
            overrun_r    <= overrun_r | bus.bit_valid;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          data_valid_r <= 1'b0;
          count_r      <= 3'd0;
          sel_r        <= sel_map(3'd0, LSB_FIRST_B);
        end
      endcase
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.busy       = busy_r;
  assign bus.sel_out    = sel_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_bit_deser_8x1.sv
// Directed and random checks of bit_deser_8x1 in both bit orders against a
// queue-based model of the capture rules.
module tb_bit_deser_8x1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bit_deser_8x1_if ifl ();
  bit_deser_8x1_if ifm ();

  bit_deser_8x1 #(.LSB_FIRST(1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(ifl));
  bit_deser_8x1 #(.LSB_FIRST(0)) dut_m (.clk(clk), .rst_n(rst_n), .bus(ifm));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 capturing, 2 byte held
  int       m_phase;
  bit       m_q[$];
  bit [7:0] m_data_l;
  bit [7:0] m_data_m;
  bit       m_dv;
  bit       m_ovr;

  function automatic bit [7:0] to_byte(input bit lsb);
    bit [7:0] b;
    b = 8'h00;
    for (int i = 0; i < m_q.size(); i++) begin
      if (lsb) b[i] = m_q[i];
      else     b[7-i] = m_q[i];
    end
    return b;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_q.delete();
    m_data_l = 8'h00;
    m_data_m = 8'h00;
    m_dv     = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit bv, input bit bi, input bit dr);
    case (m_phase)
      0: if (st) begin m_phase = 1; m_q.delete(); m_ovr = 1'b0; end
      1: begin
        if (st) m_q.delete();
        else if (bv) begin
          m_q.push_back(bi);
          if (m_q.size() == 8) begin
            m_data_l = to_byte(1'b1);
            m_data_m = to_byte(1'b0);
            m_dv     = 1'b1;
            m_phase  = 2;
            m_q.delete();
          end
        end
      end
      default: begin
        if (dr && st) begin
          m_dv = 1'b0; m_phase = 1; m_ovr = 1'b0;
        end else begin
          if (bv) m_ovr = 1'b1;
          if (dr) begin m_dv = 1'b0; m_phase = 0; end
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit [7:0] n;
    n = 8'(m_q.size());
    chk("l_data",  ifl.data_out,        m_data_l);
    chk("l_valid", 8'(ifl.data_valid),  8'(m_dv));
    chk("l_busy",  8'(ifl.busy),        8'(m_phase == 1));
    chk("l_sel",   8'(ifl.sel_out),     n);
    chk("l_ovr",   8'(ifl.overrun),     8'(m_ovr));
    chk("m_data",  ifm.data_out,        m_data_m);
    chk("m_valid", 8'(ifm.data_valid),  8'(m_dv));
    chk("m_busy",  8'(ifm.busy),        8'(m_phase == 1));
    chk("m_sel",   8'(ifm.sel_out),     8'd7 - n);
    chk("m_ovr",   8'(ifm.overrun),     8'(m_ovr));
  endtask

  task automatic step(input bit st, input bit bv, input bit bi, input bit dr);
    ifl.start = st; ifl.bit_valid = bv; ifl.bit_in = bi; ifl.data_ready = dr;
    ifm.start = st; ifm.bit_valid = bv; ifm.bit_in = bi; ifm.data_ready = dr;
    @(posedge clk);
    model_step(st, bv, bi, dr);
    #1;
    check_all();
  endtask

  task automatic send_byte(input bit [7:0] v);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, v[i], 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    ifl.start = 1'b0; ifl.bit_valid = 1'b0; ifl.bit_in = 1'b0; ifl.data_ready = 1'b0;
    ifm.start = 1'b0; ifm.bit_valid = 1'b0; ifm.bit_in = 1'b0; ifm.data_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("rst_sel_m", 8'(ifm.sel_out), 8'd7);
    @(negedge clk) rst_n = 1'b1;

    // A5 capture, sel walking 0..7 / 7..0, valid in cycle 9
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("busy_after_start", 8'(ifl.busy), 8'd1);
    send_byte(8'hA5);
    chk("a5_lsb", ifl.data_out, 8'hA5);
    chk("a5_msb", ifm.data_out, 8'hA5);
    chk("a5_valid", 8'(ifl.data_valid), 8'd1);

    // back-to-back: handshake with start, then 5A
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("b2b_busy", 8'(ifl.busy), 8'd1);
    send_byte(8'h5A);
    chk("5a_lsb", ifl.data_out, 8'h5A);

    // backpressure with one stray bit
    for (int i = 0; i < 5; i++) step(1'b0, (i == 2), 1'b1, 1'b0);
    chk("hold_data", ifl.data_out, 8'h5A);
    chk("hold_ovr", 8'(ifl.overrun), 8'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_sticky_idle", 8'(ifl.overrun), 8'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovr_cleared", 8'(ifl.overrun), 8'd0);

    // gapped 3C stream
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h3C >> i, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("gap_busy", 8'(ifl.busy), 8'd1);
    for (int i = 4; i < 8; i++) step(1'b0, 1'b1, 8'h3C >> i, 1'b0);
    chk("3c_lsb", ifl.data_out, 8'h3C);
    chk("3c_msb", ifm.data_out, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // restart after 5 bits, then FF
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'hFF);
    chk("ff_lsb", ifl.data_out, 8'hFF);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send_byte(8'h01);
    chk("01_lsb", ifl.data_out, 8'h01);
    chk("80_msb", ifm.data_out, 8'h80);

    // async reset mid-capture
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
